// File: rtl/sprite_compositor_if.sv
// Pixel, sprite-configuration and texture bus between the VGA timing generator,
// the external texture/background ROMs and the sprite compositor.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int SIZE_W      = 4,
    parameter int COLOR_W     = 3
);
    logic                            frame_start;
    logic                            pix_valid;
    logic [XW-1:0]                   xvga;
    logic [YW-1:0]                   yvga;
    logic [NUM_SPRITES*XW-1:0]       spr_x;
    logic [NUM_SPRITES*YW-1:0]       spr_y;
    logic [NUM_SPRITES*SIZE_W-1:0]   spr_w;
    logic [NUM_SPRITES*SIZE_W-1:0]   spr_h;
    logic [NUM_SPRITES-1:0]          spr_en;
    logic [NUM_SPRITES*SIZE_W-1:0]   tex_u;
    logic [NUM_SPRITES*SIZE_W-1:0]   tex_v;
    logic [NUM_SPRITES*COLOR_W-1:0]  tex_color;
    logic [COLOR_W-1:0]              bg_color;
    logic [COLOR_W-1:0]              color;
    logic                            color_valid;
    logic [NUM_SPRITES-1:0]          collision;

    modport master (
        output frame_start, pix_valid, xvga, yvga,
        output spr_x, spr_y, spr_w, spr_h, spr_en,
        output tex_color, bg_color,
        input  tex_u, tex_v, color, color_valid, collision
    );

    modport slave (
        input  frame_start, pix_valid, xvga, yvga,
        input  spr_x, spr_y, spr_w, spr_h, spr_en,
        input  tex_color, bg_color,
        output tex_u, tex_v, color, color_valid, collision
    );
endinterface

// File: rtl/sprite_compositor.sv
// Pipelined N-channel sprite compositor: frame-committed sprite geometry, colour-keyed
// transparency, fixed channel priority (0 highest) and per-frame collision flags.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int SIZE_W      = 4,
    parameter int COLOR_W     = 3,
    parameter int TRANSPARENT = 0
) (
    input  logic               VGA_CLK,
    input  logic               rst_n,
    sprite_compositor_if.slave bus
);
    localparam logic [COLOR_W-1:0] LP_KEY = COLOR_W'(TRANSPARENT);

    logic [NUM_SPRITES*XW-1:0]      r_ax;
    logic [NUM_SPRITES*YW-1:0]      r_ay;
    logic [NUM_SPRITES*SIZE_W-1:0]  r_aw;
    logic [NUM_SPRITES*SIZE_W-1:0]  r_ah;
    logic [NUM_SPRITES-1:0]         r_aen;

    logic [NUM_SPRITES-1:0]         r_hit1;
    logic [NUM_SPRITES-1:0]         r_hit2;
    logic                           r_pv1;
    logic                           r_pv2;
    logic [NUM_SPRITES*SIZE_W-1:0]  r_tex_u;
    logic [NUM_SPRITES*SIZE_W-1:0]  r_tex_v;
    logic [COLOR_W-1:0]             r_color;
    logic                           r_cvalid;
    logic [NUM_SPRITES-1:0]         r_coll_acc;
    logic [NUM_SPRITES-1:0]         r_collision;

    logic [NUM_SPRITES-1:0]         w_hit;
    logic [NUM_SPRITES*SIZE_W-1:0]  w_u;
    logic [NUM_SPRITES*SIZE_W-1:0]  w_v;
    logic [NUM_SPRITES-1:0]         w_opq;
    logic [NUM_SPRITES-1:0]         w_coll_new;
    logic [COLOR_W-1:0]             w_pix;

    // One extra bit on the bounds keeps sprites near the right/bottom edge from wrapping.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
        logic [XW:0] w_x_lo;
        logic [XW:0] w_x_hi;
        logic [XW:0] w_px;
        logic [YW:0] w_y_lo;
        logic [YW:0] w_y_hi;
        logic [YW:0] w_py;

        assign w_px   = {1'b0, bus.xvga};
        assign w_py   = {1'b0, bus.yvga};
        assign w_x_lo = {1'b0, r_ax[g*XW +: XW]};
        assign w_y_lo = {1'b0, r_ay[g*YW +: YW]};
        assign w_x_hi = w_x_lo + {{(XW+1-SIZE_W){1'b0}}, r_aw[g*SIZE_W +: SIZE_W]};
        assign w_y_hi = w_y_lo + {{(YW+1-SIZE_W){1'b0}}, r_ah[g*SIZE_W +: SIZE_W]};

        assign w_hit[g] = r_aen[g] && (w_px >= w_x_lo) && (w_px < w_x_hi)
                                   && (w_py >= w_y_lo) && (w_py < w_y_hi);

        assign w_u[g*SIZE_W +: SIZE_W] = w_hit[g]
            ? (bus.xvga[SIZE_W-1:0] - r_ax[g*XW +: SIZE_W]) : '0;
        assign w_v[g*SIZE_W +: SIZE_W] = w_hit[g]
            ? (bus.yvga[SIZE_W-1:0] - r_ay[g*YW +: SIZE_W]) : '0;
    end

    always_comb begin
        w_opq = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_opq[i] = r_hit2[i] && (bus.tex_color[i*COLOR_W +: COLOR_W] != LP_KEY);
        end
    end

    // Descending scan so the lowest-index opaque channel is the last writer.
    always_comb begin
        w_pix = bus.bg_color;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opq[i]) begin
                w_pix = bus.tex_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Two or more bits set <=> clearing the lowest set bit leaves something behind.
    assign w_coll_new = (r_pv2 && ((w_opq & (w_opq - NUM_SPRITES'(1))) != '0)) ? w_opq : '0;

    always_ff @(posedge VGA_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ax        <= '0;
            r_ay        <= '0;
            r_aw        <= '0;
            r_ah        <= '0;
            r_aen       <= '0;
            r_hit1      <= '0;
            r_hit2      <= '0;
            r_pv1       <= 1'b0;
            r_pv2       <= 1'b0;
            r_tex_u     <= '0;
            r_tex_v     <= '0;
            r_color     <= '0;
            r_cvalid    <= 1'b0;
            r_coll_acc  <= '0;
            r_collision <= '0;
        end else begin
            if (bus.frame_start) begin
                r_ax        <= bus.spr_x;
                r_ay        <= bus.spr_y;
                r_aw        <= bus.spr_w;
                r_ah        <= bus.spr_h;
                r_aen       <= bus.spr_en;
                r_collision <= r_coll_acc | w_coll_new;
                r_coll_acc  <= '0;
            end else begin
                r_coll_acc  <= r_coll_acc | w_coll_new;
            end
            r_hit1   <= w_hit;
            r_pv1    <= bus.pix_valid;
            r_tex_u  <= w_u;
            r_tex_v  <= w_v;
            r_hit2   <= r_hit1;
            r_pv2    <= r_pv1;
            r_cvalid <= r_pv2;
            r_color  <= r_pv2 ? w_pix : '0;
        end
    end

    assign bus.tex_u       = r_tex_u;
    assign bus.tex_v       = r_tex_v;
    assign bus.color       = r_color;
    assign bus.color_valid = r_cvalid;
    assign bus.collision   = r_collision;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with registered ROM models and a colour scoreboard.
module tb_sprite_compositor;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int SW = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [CW-1:0] col;
        logic          vld;
    } exp_t;

    logic VGA_CLK = 1'b0;
    logic rst_n   = 1'b0;

    sprite_compositor_if #(.NUM_SPRITES(N), .XW(XW), .YW(YW), .SIZE_W(SW), .COLOR_W(CW)) bus ();

    sprite_compositor #(.NUM_SPRITES(N), .XW(XW), .YW(YW), .SIZE_W(SW), .COLOR_W(CW),
                        .TRANSPARENT(0)) dut (
        .VGA_CLK (VGA_CLK),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int checks = 0;
    int errors = 0;

    // Sprite configuration presented on the inputs, and the model's committed copy.
    int c_x[N], c_y[N], c_w[N], c_h[N], c_en[N];
    int m_x[N], m_y[N], m_w[N], m_h[N], m_en[N];
    int spr_col[N];
    logic [N-1:0] acc;
    logic [N-1:0] exp_coll;
    exp_t q[$];

    function automatic logic [CW-1:0] bg_fn(input int x, input int y);
        return CW'(x ^ (y * 3));
    endfunction

    function automatic logic [CW-1:0] tex_fn(input int i, input int u, input int v);
        if (spr_col[i] == 0) return '0;
        return CW'(((spr_col[i] - 1 + u + v) % 7) + 1);
    endfunction

    // External ROMs: texture registered one cycle after tex_u/v, background delayed to match.
    logic [CW-1:0] bg_d1, bg_d2;
    logic [CW-1:0] rom_q[N];
    always @(posedge VGA_CLK) begin
        bg_d1 <= bg_fn(int'(bus.xvga), int'(bus.yvga));
        bg_d2 <= bg_d1;
        for (int i = 0; i < N; i++)
            rom_q[i] <= tex_fn(i, int'(bus.tex_u[i*SW +: SW]), int'(bus.tex_v[i*SW +: SW]));
    end

    always_comb begin
        bus.bg_color  = bg_d2;
        bus.tex_color = '0;
        for (int i = 0; i < N; i++) bus.tex_color[i*CW +: CW] = rom_q[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int x, input int y, input bit pv, input bit fs);
        exp_t e, o;
        logic [N-1:0] op;
        int u[N], v[N];
        bit h;
        bus.xvga        = XW'(x);
        bus.yvga        = YW'(y);
        bus.pix_valid   = pv;
        bus.frame_start = fs;
        for (int i = 0; i < N; i++) begin
            bus.spr_x[i*XW +: XW] = XW'(c_x[i]);
            bus.spr_y[i*YW +: YW] = YW'(c_y[i]);
            bus.spr_w[i*SW +: SW] = SW'(c_w[i]);
            bus.spr_h[i*SW +: SW] = SW'(c_h[i]);
            bus.spr_en[i]         = (c_en[i] != 0);
        end
        op = '0;
        for (int i = 0; i < N; i++) begin
            h = (m_en[i] != 0) && x >= m_x[i] && x < m_x[i] + m_w[i]
                               && y >= m_y[i] && y < m_y[i] + m_h[i];
            u[i] = h ? ((x - m_x[i]) & 15) : 0;
            v[i] = h ? ((y - m_y[i]) & 15) : 0;
            if (h && tex_fn(i, u[i], v[i]) != 0) op[i] = 1'b1;
        end
        e.vld = pv;
        e.col = '0;
        if (pv) begin
            e.col = bg_fn(x, y);
            for (int i = N - 1; i >= 0; i--)
                if (op[i]) e.col = tex_fn(i, u[i], v[i]);
            if ($countones(op) >= 2) acc |= op;
        end
        q.push_back(e);
        if (fs) begin
            exp_coll = acc;
            acc      = '0;
            m_x = c_x; m_y = c_y; m_w = c_w; m_h = c_h; m_en = c_en;
        end
        @(posedge VGA_CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("tex_u", 32'(bus.tex_u[i*SW +: SW]), u[i]);
            chk("tex_v", 32'(bus.tex_v[i*SW +: SW]), v[i]);
        end
        chk("collision", 32'(bus.collision), 32'(exp_coll));
        if (q.size() == 3) begin
            o = q.pop_front();
            chk("color_valid", 32'(bus.color_valid), 32'(o.vld));
            chk("color", 32'(bus.color), 32'(o.col));
        end
    endtask

    task automatic blank(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame_sync();
        blank(4);
        tick(0, 0, 1'b0, 1'b1);
        blank(2);
    endtask

    task automatic scan(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) tick(x % 256, y, 1'b1, 1'b0);
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int w, input int h, input int en);
        c_x[i] = x; c_y[i] = y; c_w[i] = w; c_h[i] = h; c_en[i] = en;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0; m_en[i] = 0;
        end
        acc      = '0;
        exp_coll = '0;
        q.delete();
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.xvga        = '0;
        bus.yvga        = '0;
        bus.spr_x       = '0;
        bus.spr_y       = '0;
        bus.spr_w       = '0;
        bus.spr_h       = '0;
        bus.spr_en      = '0;
        for (int i = 0; i < N; i++) begin
            set_spr(i, 0, 0, 0, 0, 0);
            spr_col[i] = i + 2;
        end
        clear_model();

        repeat (3) @(posedge VGA_CLK);
        #1;
        chk("rst_color", 32'(bus.color), 0);
        chk("rst_color_valid", 32'(bus.color_valid), 0);
        chk("rst_collision", 32'(bus.collision), 0);
        chk("rst_tex_u", 32'(bus.tex_u), 0);
        chk("rst_tex_v", 32'(bus.tex_v), 0);
        rst_n = 1'b1;

        // Sprite requested but never committed: background only.
        set_spr(0, 0, 0, 4, 8, 1);
        blank(3);
        scan(5, 0, 15);
        blank(3);

        // Sprite 0 at (10,20) 4x4.
        set_spr(0, 10, 20, 4, 4, 1);
        spr_col[0] = 5;
        frame_sync();
        scan(21, 8, 15);
        blank(3);

        // Overlap with sprite 1: sprite 0 wins, then sprite 0 transparent.
        set_spr(1, 11, 20, 4, 4, 1);
        spr_col[1] = 3;
        frame_sync();
        scan(21, 8, 16);
        blank(3);
        spr_col[0] = 0;
        blank(3);
        scan(21, 8, 16);
        frame_sync();

        // Sprites 1 and 2 overlap: flags published one frame later, cleared the next.
        spr_col[0] = 5;
        set_spr(0, 0, 0, 0, 0, 0);
        set_spr(1, 30, 40, 4, 4, 1);
        set_spr(2, 32, 41, 4, 4, 1);
        spr_col[2] = 6;
        frame_sync();
        scan(42, 28, 37);
        frame_sync();
        frame_sync();

        // Right-edge clipping.
        set_spr(1, 0, 0, 0, 0, 0);
        set_spr(2, 0, 0, 0, 0, 0);
        set_spr(3, 254, 0, 4, 2, 1);
        spr_col[3] = 4;
        frame_sync();
        scan(1, 250, 259);
        blank(3);

        // Position change without frame_start is ignored until the commit.
        c_x[3] = 100;
        blank(3);
        scan(1, 250, 259);
        scan(1, 98, 103);
        frame_sync();
        scan(1, 98, 103);
        scan(1, 250, 259);

        // Asynchronous reset mid-line.
        scan(1, 99, 101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_color", 32'(bus.color), 0);
        chk("async_rst_color_valid", 32'(bus.color_valid), 0);
        chk("async_rst_collision", 32'(bus.collision), 0);
        clear_model();
        repeat (2) @(posedge VGA_CLK);
        #1;
        rst_n = 1'b1;
        blank(3);
        scan(1, 98, 103);
        blank(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised N-channel sprite compositor. Replaces the fixed ball/paddle/paddle priority mux with a pipelined, per-channel-configurable stage.
- Sits between the VGA timing generator and the DAC colour register.
- Sprite positions and sizes are double-buffered and take effect only at frame boundaries. Texels equal to a colour key are transparent. Per-sprite collision flags are reported once per frame.
- Sprite texture ROMs and the background ROM stay external. The block drives texture addresses and consumes the returned colours.

Parameters:
NUM_SPRITES, 4, number of sprite channels; index 0 has highest priority
XW, 8, horizontal pixel coordinate width
YW, 7, vertical pixel coordinate width
SIZE_W, 4, sprite width/height/texel-address width
COLOR_W, 3, colour width
TRANSPARENT, 0, colour-key value treated as see-through

Ports:
VGA_CLK  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle pulse in vertical blank; commits shadow regs and publishes collisions
pix_valid  in  1  current xvga/yvga is in the visible area
xvga  in  XW  current pixel x
yvga  in  YW  current pixel y
spr_x  in  NUM_SPRITES*XW  packed sprite left edges; channel i at bits [i*XW +: XW]
spr_y  in  NUM_SPRITES*YW  packed sprite top edges
spr_w  in  NUM_SPRITES*SIZE_W  packed widths in pixels; 0 means empty
spr_h  in  NUM_SPRITES*SIZE_W  packed heights in pixels
spr_en  in  NUM_SPRITES  per-channel enable
tex_u  out  NUM_SPRITES*SIZE_W  registered texel column per channel
tex_v  out  NUM_SPRITES*SIZE_W  registered texel row per channel
tex_color  in  NUM_SPRITES*COLOR_W  texel colours from external registered ROMs
bg_color  in  COLOR_W  background colour, aligned with tex_color
color  out  COLOR_W  composited pixel colour
color_valid  out  1  color belongs to a visible pixel
collision  out  NUM_SPRITES  per-sprite "overlapped another opaque sprite" flags for the previous frame

Behaviour:

Reset (rst_n low, asynchronous):
- All pipeline, shadow and accumulator registers clear to 0.
- Resulting outputs: color=0, color_valid=0, collision=0, tex_u=tex_v=0.
- Active spr_en=0, so no sprite displays until the first frame_start.

Shadow commit:
- On an edge with frame_start=1, active {x,y,w,h,en} <= the spr_* inputs.
- Stage 0 uses the new values from the next edge onward.
- Pixels already in the pipeline are unaffected.

Stage 0 (combinational on edge k inputs), per channel i:
- hit_i = en_i && x >= sx_i && x < sx_i + w_i && y >= sy_i && y < sy_i + h_i.
- Sums are computed at XW+1 / YW+1 bits. Sprites clip at the screen edge and never wrap.
- w_i=0 or h_i=0 gives no hit.

Stage 1 (edge k+1):
- Register hit_i and pix_valid.
- tex_u_i <= (x - sx_i)[SIZE_W-1:0] and tex_v_i <= (y - sy_i)[SIZE_W-1:0] when hit_i; otherwise 0.

Stage 2 (edge k+2):
- Sample tex_color and bg_color. The external ROMs must return data one cycle after tex_u/tex_v; the integrator delays the background ROM to match.
- opaque_i = hit_i && tex_color_i != TRANSPARENT.

Stage 3 (edge k+3):
- color <= tex_color of the lowest-index opaque channel, else bg_color.
- color_valid <= delayed pix_valid.
- If delayed pix_valid=0, color <= 0 (blanking).
- Total latency from xvga/yvga to color is 3 cycles; throughput is 1 pixel/clock.

Collision accumulation (at stage 2/3):
- When two or more opaque_i are set on a valid pixel, set coll_acc bit i for every opaque channel.
- On a frame_start edge: collision <= coll_acc | same-cycle contributions, then coll_acc <= 0.
- collision holds until the next frame_start.

Boundary conditions:
- frame_start is asserted only while pix_valid=0.
- frame_start while pix_valid=1 is still honoured: commit and publish happen immediately, with no gating.
- Reset mid-frame clears everything; output is blanked until pipeline refill and the next frame_start.

Test Plan:
- Reset, then stream a frame without frame_start. Required: color = bg_color delayed 3 cycles; collision=0; no sprite pixels.
- Sprite 0 at (10,20), w=4, h=4, en=1, committed by frame_start. Scan y=21, x=8..15. Required: tex_u = 0..3 for x=10..13 one cycle after each input; color = tex_color_0 exactly for those 4 pixels, 3 cycles later.
- Sprites 0 and 1 overlap, both opaque. Required: sprite 0 colour wins. Then make sprite 0 texel = TRANSPARENT: sprite 1 colour shows, and that pixel causes no collision.
- Opaque overlap of sprites 1 and 2 during frame F. Required: collision=3'b110 (N=4: 4'b0110) after F+1's frame_start; cleared after F+2's frame_start if no overlap occurs in F+1.
- Sprite x=254, w=4, XW=8. Required: hit only at x=254,255; no hit at x=0,1 (no wrap).
- Change spr_x mid-frame without frame_start. Required: on-screen position unchanged until the next frame_start. Assert rst_n low mid-line: color=0 and color_valid=0 immediately (asynchronous).
